// File: rtl/fetch_pkg.sv
// Shared constants and the queue entry type for the LC-3b decoupled fetch unit.
package fetch_pkg;

  localparam logic [1:0]  PCMUX_SEQ        = 2'd0;
  localparam logic [1:0]  PCMUX_TARGET     = 2'd1;
  localparam logic [1:0]  PCMUX_TRAP       = 2'd2;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h3000;
  localparam int          FQ_ADDR_W        = 16;
  localparam int          FQ_INSTR_W       = 16;

  typedef struct packed {
    logic [FQ_ADDR_W-1:0]  npc;
    logic [FQ_INSTR_W-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; the count register tells full from empty.
module sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign rdata  = r_mem[r_head];
  assign w_push = push & ~full & ~flush;
  assign w_pop  = pop & ~empty & ~flush;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= ptr_inc(r_tail);
      if (w_pop)  r_head <= ptr_inc(r_head);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch: PC, imem handshake, prefetch queue of {npc, ir} and the DE latch.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int               DEPTH    = 4,
  parameter  int               ADDR_W   = 16,
  parameter  int               INSTR_W  = 16,
  parameter  logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter  int               PC_INC   = 2,
  localparam int               CW       = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_r,
  input  logic               dep_stall,
  input  logic               mem_stall,
  input  logic               v_de_br_stall,
  input  logic               v_agex_br_stall,
  input  logic               v_mem_br_stall,
  input  logic [1:0]         mem_pcmux,
  input  logic [ADDR_W-1:0]  target_pc,
  input  logic [ADDR_W-1:0]  trap_pc,
  output logic [ADDR_W-1:0]  de_npc,
  output logic [INSTR_W-1:0] de_ir,
  output logic               de_v,
  output logic [CW-1:0]      q_count
);

  localparam int EW = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_de_npc;
  logic [INSTR_W-1:0] r_de_ir;
  logic               r_de_v;

  logic [ADDR_W-1:0]  w_pc_inc;
  logic               w_full;
  logic               w_empty;
  logic               w_br_stall;
  logic               w_de_ld;
  logic               w_redirect;
  logic               w_push;
  logic               w_pop;
  logic [EW-1:0]      w_head;

  assign w_pc_inc   = r_pc + ADDR_W'(PC_INC);
  assign w_br_stall = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;
  assign w_de_ld    = ~(dep_stall | mem_stall);
  assign w_redirect = v_mem_br_stall & ~mem_stall &
                      ((mem_pcmux == PCMUX_TARGET) | (mem_pcmux == PCMUX_TRAP));

  // Request depends only on queue space, never on decode, so no combinational loop.
  assign imem_req   = rst_n & ~w_full;
  assign imem_addr  = r_pc;
  assign w_push     = imem_req & imem_r & ~w_redirect;
  assign w_pop      = w_de_ld & ~w_br_stall & ~w_empty & ~w_redirect;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_redirect),
    .wdata ({w_pc_inc, imem_rdata}),
    .rdata (w_head),
    .count (q_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= (mem_pcmux == PCMUX_TARGET) ? target_pc : trap_pc;
    end else if (w_push) begin
      r_pc <= w_pc_inc;
    end
  end

  // A redirect kills the DE instruction even under dep_stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de_v   <= 1'b0;
      r_de_npc <= '0;
      r_de_ir  <= '0;
    end else if (w_redirect) begin
      r_de_v   <= 1'b0;
    end else if (w_pop) begin
      r_de_v   <= 1'b1;
      r_de_npc <= w_head[EW-1:INSTR_W];
      r_de_ir  <= w_head[INSTR_W-1:0];
    end else if (w_de_ld) begin
      r_de_v   <= 1'b0;
    end
  end

  assign de_npc = r_de_npc;
  assign de_ir  = r_de_ir;
  assign de_v   = r_de_v;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random stimulus for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   imem_addr;
  logic          imem_req;
  logic [15:0]   imem_rdata;
  logic          imem_r;
  logic          dep_stall, mem_stall;
  logic          v_de_br_stall, v_agex_br_stall, v_mem_br_stall;
  logic [1:0]    mem_pcmux;
  logic [15:0]   target_pc, trap_pc;
  logic [15:0]   de_npc, de_ir;
  logic          de_v;
  logic [CW-1:0] q_count;

  int errors = 0;
  int checks = 0;

  fetch_entry_t m_q[$];
  logic [15:0]  m_pc, m_dnpc, m_dir;
  logic         m_dv;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_r(imem_r),
    .dep_stall(dep_stall), .mem_stall(mem_stall),
    .v_de_br_stall(v_de_br_stall), .v_agex_br_stall(v_agex_br_stall),
    .v_mem_br_stall(v_mem_br_stall), .mem_pcmux(mem_pcmux),
    .target_pc(target_pc), .trap_pc(trap_pc),
    .de_npc(de_npc), .de_ir(de_ir), .de_v(de_v), .q_count(q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = RESET_PC_DEFAULT;
    m_q.delete();
    m_dv   = 1'b0;
    m_dnpc = '0;
    m_dir  = '0;
  endtask

  // One clock of the fetch rules, evaluated on the inputs currently driven.
  task automatic model_step();
    bit red, de_ld, brs, req;
    fetch_entry_t e;
    red   = v_mem_br_stall && !mem_stall && (mem_pcmux == 2'd1 || mem_pcmux == 2'd2);
    de_ld = !(dep_stall || mem_stall);
    brs   = v_de_br_stall || v_agex_br_stall || v_mem_br_stall;
    req   = (m_q.size() < DEPTH);
    if (red) begin
      m_pc = (mem_pcmux == 2'd1) ? target_pc : trap_pc;
      m_q.delete();
      m_dv = 1'b0;
    end else begin
      if (de_ld) begin
        if (!brs && m_q.size() != 0) begin
          e      = m_q.pop_front();
          m_dnpc = e.npc;
          m_dir  = e.ir;
          m_dv   = 1'b1;
        end else begin
          m_dv = 1'b0;
        end
      end
      if (req && imem_r) begin
        e.npc = m_pc + 16'd2;
        e.ir  = imem_rdata;
        m_q.push_back(e);
        m_pc  = m_pc + 16'd2;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imem_addr"}, imem_addr, m_pc);
    chk({tag, ".imem_req"},  imem_req,  (rst_n && m_q.size() != DEPTH));
    chk({tag, ".q_count"},   q_count,   m_q.size());
    chk({tag, ".de_v"},      de_v,      m_dv);
    chk({tag, ".de_npc"},    de_npc,    m_dnpc);
    chk({tag, ".de_ir"},     de_ir,     m_dir);
  endtask

  task automatic idle();
    imem_r = 0; dep_stall = 0; mem_stall = 0;
    v_de_br_stall = 0; v_agex_br_stall = 0; v_mem_br_stall = 0;
    mem_pcmux = 2'd0; target_pc = 16'h0; trap_pc = 16'h0;
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic cycle(input string tag);
    imem_rdata = mem_word(imem_addr);
    model_step();
    @(posedge clk); #1;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    idle();
    imem_rdata = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all("reset");
    chk("reset.req_low", imem_req, 1'b0);
    rst_n = 1'b1;

    // Streaming fetch with a ready memory
    imem_r = 1;
    chk("seq.addr0", imem_addr, 16'h3000);
    cycle("seq1");
    chk("seq.addr1", imem_addr, 16'h3002);
    cycle("seq2");
    chk("seq.addr2", imem_addr, 16'h3004);
    chk("seq.de_v", de_v, 1'b1);
    chk("seq.de_npc", de_npc, 16'h3002);
    chk("seq.de_ir", de_ir, mem_word(16'h3000));
    cycle("seq3");

    // Decode stall fills the queue
    dep_stall = 1;
    for (int i = 0; i < 6; i++) cycle("dep");
    chk("dep.full", q_count, DEPTH);
    chk("dep.noreq", imem_req, 1'b0);
    dep_stall = 0;
    for (int i = 0; i < 8; i++) cycle("drain");

    // Branch in AGEX, resolves sequentially in MEM
    v_agex_br_stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle("agex");
      chk("agex.bubble", de_v, 1'b0);
    end
    v_agex_br_stall = 0; v_mem_br_stall = 1; mem_pcmux = 2'd0;
    cycle("mem_seq");
    chk("mem_seq.noflush", q_count, DEPTH);
    v_mem_br_stall = 0;
    for (int i = 0; i < 4; i++) cycle("post_seq");

    // Taken branch with three entries queued
    dep_stall = 1; imem_r = 0;
    cycle("prep");
    imem_r = 1;
    for (int i = 0; i < 8 && m_q.size() < 3; i++) cycle("fill3");
    chk("fill3.count", q_count, 3);
    dep_stall = 0; imem_r = 1;
    v_mem_br_stall = 1; mem_pcmux = 2'd1; target_pc = 16'h4000;
    cycle("redir");
    chk("redir.q_count", q_count, 0);
    chk("redir.de_v", de_v, 1'b0);
    chk("redir.addr", imem_addr, 16'h4000);
    v_mem_br_stall = 0; mem_pcmux = 2'd0;
    cycle("redir1");
    cycle("redir2");
    chk("redir.de_npc", de_npc, 16'h4002);

    // Trap with mem_stall blocking, then taking effect
    v_mem_br_stall = 1; mem_pcmux = 2'd2; trap_pc = 16'h0200; mem_stall = 1;
    cycle("trap_blk");
    mem_stall = 0;
    cycle("trap");
    chk("trap.addr", imem_addr, 16'h0200);
    chk("trap.q_count", q_count, 0);
    v_mem_br_stall = 0; mem_pcmux = 2'd0;
    for (int i = 0; i < 3; i++) cycle("post_trap");

    // PC wrap at the top of the address space
    v_mem_br_stall = 1; mem_pcmux = 2'd1; target_pc = 16'hFFFE;
    cycle("wrap_redir");
    v_mem_br_stall = 0; mem_pcmux = 2'd0;
    cycle("wrap");
    chk("wrap.addr", imem_addr, 16'h0000);
    cycle("wrap2");
    chk("wrap.de_npc", de_npc, 16'h0000);

    // Slow memory, then reset in the middle of a request
    for (int i = 0; i < 12; i++) begin
      imem_r = (i % 3 == 0);
      cycle("slow");
    end
    imem_r = 1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle("after_rst");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      imem_r          = ($urandom_range(0, 3) != 0);
      dep_stall       = ($urandom_range(0, 4) == 0);
      mem_stall       = ($urandom_range(0, 6) == 0);
      v_de_br_stall   = ($urandom_range(0, 9) == 0);
      v_agex_br_stall = ($urandom_range(0, 9) == 0);
      v_mem_br_stall  = ($urandom_range(0, 7) == 0);
      mem_pcmux       = 2'($urandom_range(0, 3));
      target_pc       = 16'($urandom) & 16'hFFFE;
      trap_pc         = 16'($urandom) & 16'hFFFE;
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
